// File: rtl/bus_uart_tx.sv
// -----------------------------------------------------------------------------
// bus_uart_tx
// Memory-mapped 8N1 UART transmitter hanging off the core's data bus.
// A 16-byte register window at BASE_ADDR accepts bytes into a small TX FIFO,
// exposes a status word and a baud divider, and a four-state FSM serialises
// the buffered bytes LSB first on tx.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-low reset (reset==0 resets at the edge)
//   MemWrite   core store strobe, one cycle per store
//   Adr        core byte address (only [31:2] are decoded)
//   WriteData  core store data
//   hit        1 when Adr falls in this block's 16-byte window
//   rdata      read data for the addressed register, 0 when hit==0
//   tx         serial output, idle high
//
// Register map (offset Adr[3:2]):
//   0x0 TXDATA  (W)  push WriteData[7:0]; reads 0
//   0x4 STATUS  (R)  {count[8:4], overflow, empty, full, busy}; write bit3 clears overflow
//   0x8 BAUDDIV (RW) clk cycles per serial bit in [15:0]
//   0xC reserved
// -----------------------------------------------------------------------------
module bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Bus decode
    logic [1:0]       offset;
    logic             wr;
    logic             push_req;
    logic             push_ok;
    logic             clear_ovf;
    logic             baud_wr;

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       count_ext;
    logic             full;
    logic             empty;
    logic             pop;
    logic [7:0]       head;

    // Control/status registers
    logic             overflow;
    logic [15:0]      bauddiv;
    logic [15:0]      eff;

    // Serialiser
    state_t           state;
    state_t           state_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [15:0]      cyc;
    logic [15:0]      cyc_next;
    logic [15:0]      bit_eff;
    logic [15:0]      bit_eff_next;
    logic             bit_done;
    logic             tx_next;
    logic             tx_q;
    logic             busy;

    // Address bits below word granularity and the upper store bits are
    // intentionally not decoded.
    logic             unused_bits;
    assign unused_bits = ^{Adr[1:0], WriteData[31:16]};

    // Window decode and per-register write strobes.
    assign hit       = (Adr[31:4] == BASE_ADDR[31:4]);
    assign offset    = Adr[3:2];
    assign wr        = MemWrite & hit;
    assign push_req  = wr && (offset == 2'd0);
    assign push_ok   = push_req && !full;
    assign clear_ovf = wr && (offset == 2'd1) && WriteData[3];
    assign baud_wr   = wr && (offset == 2'd2);

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign head      = fifo_mem[rd_ptr];
    assign count_ext = 5'(count);
    assign busy      = (state != IDLE);

    // A divider of 0 would never complete a bit, so it behaves as 1.
    assign eff       = (bauddiv == 16'd0) ? 16'd1 : bauddiv;

    // bit_eff is latched at each bit boundary, so a divider write mid-bit
    // only takes effect on the following bit. It is never 0.
    assign bit_done  = (cyc == (bit_eff - 16'd1));

    assign tx        = tx_q;

    // Combinational read mux; STATUS reflects pre-edge state.
    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (offset)
                2'd1:    rdata = {23'd0, count_ext, overflow, empty, full, busy};
                2'd2:    rdata = {16'd0, bauddiv};
                default: rdata = 32'd0;
            endcase
        end
    end

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy. A full FIFO drops the push even if a pop
    // happens at the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and the baud divider register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
            bauddiv  <= DEFAULT_DIV;
        end else begin
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
            if (baud_wr) begin
                bauddiv <= WriteData[15:0];
            end
        end
    end

    // Serialiser state register. tx is registered from the next-state value
    // so the line is glitch-free and changes exactly at state transitions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= 8'd0;
            bit_idx <= 3'd0;
            cyc     <= 16'd0;
            bit_eff <= 16'd1;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            cyc     <= cyc_next;
            bit_eff <= bit_eff_next;
            tx_q    <= tx_next;
        end
    end

    // Next-state logic for the frame sequencer. STOP pops the next byte
    // directly into START so back-to-back frames have no idle gap.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        cyc_next     = cyc;
        bit_eff_next = bit_eff;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    shift_next   = head;
                    bit_idx_next = 3'd0;
                    cyc_next     = 16'd0;
                    bit_eff_next = eff;
                    state_next   = START;
                end
            end

            START: begin
                if (bit_done) begin
                    cyc_next     = 16'd0;
                    bit_idx_next = 3'd0;
                    bit_eff_next = eff;
                    state_next   = DATA;
                end else begin
                    cyc_next = cyc + 16'd1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    cyc_next     = 16'd0;
                    bit_eff_next = eff;
                    shift_next   = {1'b0, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cyc_next = cyc + 16'd1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    cyc_next     = 16'd0;
                    bit_eff_next = eff;
                    if (!empty) begin
                        pop          = 1'b1;
                        shift_next   = head;
                        bit_idx_next = 3'd0;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cyc_next = cyc + 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level for the cycle after the edge, derived from the next state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_bus_uart_tx
// Directed self-checking bench for bus_uart_tx. Bus writes are driven one
// cycle each, outputs are sampled 1-2 time units after the rising edge, and
// every expected value is a hand-computed constant or a simple frame model.
// -----------------------------------------------------------------------------
module tb_bus_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX  = BASE + 32'h0;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_BD  = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        hit;
    logic [31:0] rdata;
    logic        tx;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    logic [31:0] v;
    int          busyCycles;
    int          badCycles;

    bus_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd434)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .Adr      (Adr),
        .WriteData(WriteData),
        .hit      (hit),
        .rdata    (rdata),
        .tx       (tx)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus sequence.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One bus store cycle; returns 1 unit after the edge that captured it.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        Adr       = addr;
        WriteData = data;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        Adr       = A_ST;
        WriteData = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] value);
        Adr = addr;
        #1;
        value = rdata;
        Adr = A_ST;
    endtask

    // Expected line level k cycles into a frame carrying byte b at divider eff.
    function automatic logic expTx(input logic [7:0] b, input int k, input int eff);
        int slot;
        slot = k / eff;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    initial begin
        logic [7:0] b;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        Adr       = A_ST;
        WriteData = 32'd0;

        // Reset held for two edges, then released.
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_hit", {31'd0, hit}, 32'd1);
        readReg(A_ST, v);
        checkOutput("reset_status", v, 32'h0000_0004);
        readReg(A_BD, v);
        checkOutput("reset_bauddiv", v, 32'd434);
        readReg(A_TX, v);
        checkOutput("txdata_reads_zero", v, 32'd0);
        readReg(A_RSV, v);
        checkOutput("reserved_reads_zero", v, 32'd0);

        // Single frame 0xA5 at divider 4.
        $display("[TB] single frame 0xA5, div 4");
        applyStimulus(A_BD, 32'd4);
        readReg(A_BD, v);
        checkOutput("bauddiv_4", v, 32'd4);
        applyStimulus(A_TX, 32'h0000_00A5);
        readReg(A_ST, v);
        checkOutput("a5_status_queued", v, 32'h0000_0010);
        tick();
        busyCycles = 0;
        b = 8'hA5;
        for (int k = 0; k < 44; k++) begin
            checkOutput($sformatf("a5_tx_k%0d", k), {31'd0, tx},
                        {31'd0, (k < 40) ? expTx(b, k, 4) : 1'b1});
            readReg(A_ST, v);
            if (v[0]) busyCycles++;
            tick();
        end
        checkOutput("a5_busy_cycles", busyCycles, 32'd40);

        // Two back-to-back frames at divider 2.
        $display("[TB] back-to-back frames, div 2");
        applyStimulus(A_BD, 32'd2);
        applyStimulus(A_TX, 32'h0000_0001);
        readReg(A_ST, v);
        checkOutput("b2b_status_after_push1", v, 32'h0000_0010);
        applyStimulus(A_TX, 32'h0000_0002);
        readReg(A_ST, v);
        checkOutput("b2b_status_after_push2", v, 32'h0000_0011);
        for (int k = 0; k < 40; k++) begin
            b = (k < 20) ? 8'h01 : 8'h02;
            checkOutput($sformatf("b2b_tx_k%0d", k), {31'd0, tx},
                        {31'd0, expTx(b, k % 20, 2)});
            if (k == 19) begin
                readReg(A_ST, v);
                checkOutput("b2b_status_last_stop", v, 32'h0000_0011);
            end
            if (k == 20) begin
                readReg(A_ST, v);
                checkOutput("b2b_status_second_start", v, 32'h0000_0005);
            end
            tick();
        end
        readReg(A_ST, v);
        checkOutput("b2b_status_done", v, 32'h0000_0004);
        checkOutput("b2b_tx_idle", {31'd0, tx}, 32'd1);

        // Overflow: six pushes at a slow divider.
        $display("[TB] overflow, div 100");
        applyStimulus(A_BD, 32'd100);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(A_TX, 32'h10 + i);
        end
        readReg(A_ST, v);
        checkOutput("ovf_status", v, 32'h0000_004B);
        applyStimulus(A_ST, 32'h0000_0008);
        readReg(A_ST, v);
        checkOutput("ovf_cleared_status", v, 32'h0000_0043);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        readReg(A_ST, v);
        checkOutput("ovf_reset_status", v, 32'h0000_0004);

        // Reset during DATA bit 3 of 0xA5 with a second byte queued.
        $display("[TB] reset mid-frame");
        applyStimulus(A_BD, 32'd4);
        applyStimulus(A_TX, 32'h0000_00A5);
        applyStimulus(A_TX, 32'h0000_0033);
        for (int i = 0; i < 17; i++) tick();
        checkOutput("midreset_tx_bit3", {31'd0, tx}, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("midreset_tx_at_edge", {31'd0, tx}, 32'd1);
        readReg(A_ST, v);
        checkOutput("midreset_status", v, 32'h0000_0004);
        readReg(A_BD, v);
        checkOutput("midreset_bauddiv", v, 32'd434);
        reset = 1'b1;
        badCycles = 0;
        for (int i = 0; i < 50; i++) begin
            readReg(A_ST, v);
            if (!tx || v !== 32'h0000_0004) badCycles++;
            tick();
        end
        checkOutput("midreset_quiet_cycles", badCycles, 32'd0);

        // Out-of-window access, masked divider write, reserved write.
        $display("[TB] decode boundaries");
        MemWrite  = 1'b1;
        Adr       = BASE + 32'h10;
        WriteData = 32'h0000_0055;
        #1;
        checkOutput("oow_hit", {31'd0, hit}, 32'd0);
        checkOutput("oow_rdata", rdata, 32'd0);
        tick();
        MemWrite  = 1'b0;
        Adr       = A_ST;
        WriteData = 32'd0;
        readReg(A_ST, v);
        checkOutput("oow_status", v, 32'h0000_0004);
        tick();
        checkOutput("oow_tx", {31'd0, tx}, 32'd1);
        applyStimulus(A_BD, 32'hDEAD_0007);
        readReg(A_BD, v);
        checkOutput("bauddiv_masked", v, 32'h0000_0007);
        applyStimulus(A_RSV, 32'hFFFF_FFFF);
        readReg(A_BD, v);
        checkOutput("reserved_write_ignored", v, 32'h0000_0007);

        // Divider 0 behaves as 1: ten-cycle frame of 0xFF.
        $display("[TB] divider 0");
        applyStimulus(A_BD, 32'd0);
        readReg(A_BD, v);
        checkOutput("bauddiv_0", v, 32'd0);
        applyStimulus(A_TX, 32'h0000_00FF);
        tick();
        busyCycles = 0;
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("div0_tx_k%0d", k), {31'd0, tx},
                        {31'd0, (k == 0) ? 1'b0 : 1'b1});
            readReg(A_ST, v);
            if (v[0]) busyCycles++;
            tick();
        end
        checkOutput("div0_busy_cycles", busyCycles, 32'd10);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
